upscaler_frame_sequencer: RTL

Frame-level scheduler that sits in front of `top_upscaler`. It buffers incoming 2x2 pixel quads from a valid/ready source and issues them to the upscaler as gap-free line bursts with `hsync_in` held high. It frames each picture with a `vsync_in` pulse, enforces horizontal blanking, and waits for the upscaler's last-line flush before reporting frame completion. The upscaler's row/column counters require unbroken bursts of exactly FRAME_WIDTH/2 beats; this block guarantees that.

---
 rtl/upscaler_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/upscaler_frame_sequencer.sv
// upscaler_frame_sequencer
// Buffers 2x2 pixel quads from a valid/ready source and replays them to the
// upscaler as unbroken line bursts of LINE_BEATS beats. Each picture is framed
// by a vsync pulse, bursts are separated by horizontal blanking, and completion
// is reported only after the upscaler output has been idle for DRAIN_IDLE cycles.
module upscaler_frame_sequencer #(
  parameter int DW           = 8,
  parameter int FRAME_WIDTH  = 40,
  parameter int FRAME_HEIGHT = 16,
  parameter int HBLANK       = 4,
  parameter int VS_LEN       = 2,
  parameter int DRAIN_IDLE   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DW*4-1:0]                      s_data,
  output logic                                 up_hsync,
  output logic                                 up_vsync,
  output logic [DW*4-1:0]                      up_data,
  input  logic                                 up_hsync_o,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [$clog2(FRAME_HEIGHT/2+1)-1:0]  line_idx
);

  localparam int LINE_BEATS = FRAME_WIDTH / 2;
  localparam int LINES      = FRAME_HEIGHT / 2;
  localparam int DEPTH      = 2 * LINE_BEATS;
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int LW         = $clog2(LINES + 1);
  localparam int T_A        = (VS_LEN > LINE_BEATS) ? VS_LEN : LINE_BEATS;
  localparam int T_B        = (HBLANK > DRAIN_IDLE) ? HBLANK : DRAIN_IDLE;
  localparam int TMAX       = (T_A > T_B) ? T_A : T_B;
  localparam int TW         = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BURST = 3'd3,
    ST_GAP   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_FLUSH = 3'd6
  } state_t;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [TW-1:0]     cnt_r;
  logic [CW-1:0]     count_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [DW*4-1:0]   mem_r [DEPTH];
  logic              ready_en_r;
  logic              abort_pend_r;
  logic              s_ready_s;
  logic              push_s;
  logic              pop_s;
  logic              last_beat_s;

  logic              up_hsync_r;
  logic              up_vsync_r;
  logic [DW*4-1:0]   up_data_r;
  logic              busy_r;
  logic              frame_done_r;
  logic [LW-1:0]     line_idx_r;

  logic              up_hsync_nx_s;
  logic              up_vsync_nx_s;
  logic [DW*4-1:0]   up_data_nx_s;
  logic              busy_nx_s;
  logic              frame_done_nx_s;
  logic [LW-1:0]     line_idx_nx_s;

  // The FIFO is never filled while flushing, so FLUSH can clear it in one cycle.
  assign s_ready_s   = ready_en_r && (count_r < CW'(DEPTH)) && (state_r != ST_FLUSH);
  assign push_s      = s_valid && s_ready_s;
  // A beat is popped on the edge that presents it, so up_data lines up with up_hsync.
  assign pop_s       = (next_state_s == ST_BURST);
  assign last_beat_s = (state_r == ST_BURST) && (cnt_r == TW'(LINE_BEATS - 1));

  assign s_ready    = s_ready_s;
  assign up_hsync   = up_hsync_r;
  assign up_vsync   = up_vsync_r;
  assign up_data    = up_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign line_idx   = line_idx_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; abort during a burst is deferred to the burst's last beat.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = abort ? ST_FLUSH : ST_VSYNC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        if (abort) begin
          next_state_s = ST_FLUSH;
        end else if (cnt_r == TW'(VS_LEN - 1)) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_VSYNC;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          next_state_s = ST_FLUSH;
        end else if (count_r >= CW'(LINE_BEATS)) begin
          next_state_s = ST_BURST;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_BURST: begin
        if (last_beat_s) begin
          next_state_s = (abort_pend_r || abort) ? ST_FLUSH : ST_GAP;
        end else begin
          next_state_s = ST_BURST;
        end
      end
      ST_GAP: begin
        if (abort) begin
          next_state_s = ST_FLUSH;
        end else if (cnt_r == TW'(HBLANK - 1)) begin
          next_state_s = (line_idx_r < LW'(LINES)) ? ST_WAIT : ST_DRAIN;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          next_state_s = ST_FLUSH;
        end else if (!up_hsync_o && (cnt_r == TW'(DRAIN_IDLE - 1))) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    up_hsync_nx_s   = (next_state_s == ST_BURST);
    up_vsync_nx_s   = (next_state_s == ST_VSYNC);
    busy_nx_s       = (next_state_s != ST_IDLE);
    frame_done_nx_s = (state_r == ST_DRAIN) && (next_state_s == ST_IDLE);
    if (pop_s) begin
      up_data_nx_s = mem_r[rd_ptr_r];
    end else begin
      up_data_nx_s = up_data_r;
    end
    if ((state_r == ST_IDLE) && (next_state_s == ST_VSYNC)) begin
      line_idx_nx_s = {LW{1'b0}};
    end else if (last_beat_s) begin
      line_idx_nx_s = line_idx_r + LW'(1);
    end else begin
      line_idx_nx_s = line_idx_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_hsync_r   <= 1'b0;
      up_vsync_r   <= 1'b0;
      up_data_r    <= {(DW*4){1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      line_idx_r   <= {LW{1'b0}};
    end else begin
      up_hsync_r   <= up_hsync_nx_s;
      up_vsync_r   <= up_vsync_nx_s;
      up_data_r    <= up_data_nx_s;
      busy_r       <= busy_nx_s;
      frame_done_r <= frame_done_nx_s;
      line_idx_r   <= line_idx_nx_s;
    end
  end

  // Shared per-state timer; in DRAIN it counts consecutive idle upscaler cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TW{1'b0}};
    end else if (next_state_s != state_r) begin
      cnt_r <= {TW{1'b0}};
    end else if ((state_r == ST_IDLE) || (state_r == ST_WAIT)) begin
      cnt_r <= {TW{1'b0}};
    end else if ((state_r == ST_DRAIN) && up_hsync_o) begin
      cnt_r <= {TW{1'b0}};
    end else begin
      cnt_r <= cnt_r + TW'(1);
    end
  end

  // Abort seen mid-burst is held until the burst has delivered every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_pend_r <= 1'b0;
    end else if (state_r != ST_BURST) begin
      abort_pend_r <= 1'b0;
    end else if (abort) begin
      abort_pend_r <= 1'b1;
    end else begin
      abort_pend_r <= abort_pend_r;
    end
  end

  // Source acceptance is held off for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // FIFO occupancy and pointers; FLUSH discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else if (state_r == ST_FLUSH) begin
      count_r  <= {CW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage; contents are meaningful only through the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

endmodule
